uart_rx: RTL and testbench

UART receiver that sits downstream of uart_tx and consumes its serial line (o_Tx_Serial → i_Rx_Serial).
- Frame format: 8N1 by default (1 start, DATA_WIDTH data bits LSB-first, 1 stop, no parity).
- Bit timing is set by CLKS_PER_BIT. Each bit is sampled at mid-bit.
- Each received word is presented as a one-cycle valid pulse.
- Reports framing errors.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame timing.
// Also used by uart_tx so both ends agree on the line format.
package uart_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Counter width that stays at least one bit wide for tiny ranges.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Reset value is a parameter so idle-high lines come out of reset idle.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-edge detect, mid-bit sampling, LSB-first data,
// one-cycle valid pulse on good frames and framing-error pulse on a low stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Rx_Serial,
  output logic                  o_Rx_DV,
  output logic [DATA_WIDTH-1:0] o_Rx_Data,
  output logic                  o_Rx_Active,
  output logic                  o_Rx_Frame_Err
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = cnt_w(CLKS_PER_BIT);
  localparam int BW   = cnt_w(DATA_WIDTH);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_WIDTH - 1);

  rx_state_e             state, state_d;
  logic [CW-1:0]         clk_cnt, clk_cnt_d;
  logic [BW-1:0]         bit_idx, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift, shift_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  dv_d, err_d;
  logic                  rx_s;

  uart_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk(i_Clock),
    .rst(i_Reset),
    .d  (i_Rx_Serial),
    .q  (rx_s)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= IDLE;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      shift          <= '0;
      o_Rx_Data      <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      state          <= state_d;
      clk_cnt        <= clk_cnt_d;
      bit_idx        <= bit_idx_d;
      shift          <= shift_d;
      o_Rx_Data      <= data_d;
      o_Rx_DV        <= dv_d;
      o_Rx_Frame_Err <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    clk_cnt_d = clk_cnt;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    data_d    = o_Rx_Data;
    dv_d      = 1'b0;
    err_d     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          clk_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_d = '0;
          // A start bit that is high at mid-bit was only a glitch.
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = '0;
            state_d   = DATA;
          end
        end else begin
          clk_cnt_d = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_d        = '0;
          shift_d[bit_idx] = rx_s;
          if (bit_idx == IDX_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + BW'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        // A held-low break must not be mistaken for a new start bit.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_Rx_Active = (state == START) ||
                       (state == DATA)  ||
                       (state == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed scenarios plus random frames,
// expected words and timing derived from the 8N1 frame rules.
module tb_uart_rx;

  localparam int DW   = 8;
  localparam int CPB  = 87;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + (DW + 1) * CPB;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            t;
  } exp_t;

  logic          i_Clock = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Rx_Serial = 1'b1;
  logic          o_Rx_DV;
  logic [DW-1:0] o_Rx_Data;
  logic          o_Rx_Active;
  logic          o_Rx_Frame_Err;

  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] last_good = '0;
  logic          prev_dv = 1'b0;
  int            act_run = 0;
  int            act_max = 0;
  int            act_cnt = 0;

  uart_rx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_Clock       (i_Clock),
    .i_Reset       (i_Reset),
    .i_Rx_Serial   (i_Rx_Serial),
    .o_Rx_DV       (o_Rx_DV),
    .o_Rx_Data     (o_Rx_Data),
    .o_Rx_Active   (o_Rx_Active),
    .o_Rx_Frame_Err(o_Rx_Frame_Err)
  );

  always #5 i_Clock = ~i_Clock;

  always @(posedge i_Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the receiver reports something.
  always @(negedge i_Clock) begin
    exp_t e;
    if (o_Rx_DV && o_Rx_Frame_Err)
      chk("dv_err_overlap", 1, 0);
    if (o_Rx_DV && prev_dv)
      chk("dv_single_pulse", 1, 0);
    prev_dv = o_Rx_DV;
    if (o_Rx_DV || o_Rx_Frame_Err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {30'd0, o_Rx_Frame_Err, o_Rx_DV}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("kind_err", o_Rx_Frame_Err, e.err);
        if (!e.err) begin
          chk("rx_data", o_Rx_Data, e.data);
          last_good = e.data;
        end else begin
          chk("data_held", o_Rx_Data, last_good);
        end
        n_checks++;
        if (cyc < e.t - 1 || cyc > e.t + 1) begin
          n_fail++;
          $display("FAIL latency: got cycle %0d expected %0d +-1",
                   cyc, e.t);
        end
      end
    end
    if (o_Rx_Active) begin
      act_run++;
      act_cnt++;
    end else begin
      act_run = 0;
    end
    if (act_run > act_max) act_max = act_run;
  end

  task automatic drive_bit(input logic b);
    i_Rx_Serial = b;
    repeat (CPB) @(posedge i_Clock);
    #1;
  endtask

  task automatic idle(input int n);
    i_Rx_Serial = 1'b1;
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  // Sends start, data LSB first, stop; abort_at >= 0 resets mid data bit.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop,
                            input int abort_at);
    exp_t e;
    if (abort_at < 0) begin
      e.err  = !stop;
      e.data = d;
      e.t    = cyc + LAT;
      exp_q.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) begin
      if (i == abort_at) begin
        i_Rx_Serial = d[i];
        repeat (CPB / 2) @(posedge i_Clock);
        #1 i_Reset = 1'b1;
        @(posedge i_Clock);
        #1 i_Reset = 1'b0;
        last_good   = '0;
        i_Rx_Serial = 1'b1;
        chk("abort_dv", o_Rx_DV, 0);
        chk("abort_data", o_Rx_Data, 0);
        chk("abort_active", o_Rx_Active, 0);
        chk("abort_err", o_Rx_Frame_Err, 0);
        return;
      end
      drive_bit(d[i]);
    end
    drive_bit(stop);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic          bad;
    int            gap;
    int            guard;

    repeat (3) @(posedge i_Clock);
    #1 i_Reset = 1'b0;
    chk("rst_dv", o_Rx_DV, 0);
    chk("rst_data", o_Rx_Data, 0);
    chk("rst_active", o_Rx_Active, 0);
    chk("rst_err", o_Rx_Frame_Err, 0);
    idle(20);

    send_frame(8'hA5, 1'b1, -1);
    idle(CPB);

    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(CPB);

    act_max = 0;
    i_Rx_Serial = 1'b0;
    repeat (20) @(posedge i_Clock);
    #1 idle(3 * CPB);
    n_checks++;
    if (act_max == 0 || act_max > 45) begin
      n_fail++;
      $display("FAIL glitch_active: got %0d cycles expected 1..45",
               act_max);
    end
    chk("glitch_idle", o_Rx_Active, 0);

    send_frame(8'h3C, 1'b0, -1);
    act_cnt = 0;
    i_Rx_Serial = 1'b0;
    repeat (2000) @(posedge i_Clock);
    #1;
    chk("break_no_start", act_cnt, 0);
    chk("break_data_held", o_Rx_Data, last_good);
    idle(2 * CPB);
    send_frame(8'h81, 1'b1, -1);
    idle(CPB);

    send_frame(8'hE7, 1'b1, 4);
    idle(3 * CPB);
    send_frame(8'h5A, 1'b1, -1);
    idle(CPB);

    send_frame(8'h00, 1'b1, -1);
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'hC3, 1'b1, -1);
    idle(CPB);

    for (int k = 0; k < 25; k++) begin
      rd  = DW'($urandom_range(0, 255));
      bad = ($urandom_range(0, 9) == 0);
      gap = bad ? CPB + int'($urandom_range(0, 40))
                : int'($urandom_range(0, 40));
      send_frame(rd, !bad, -1);
      if (gap > 0) idle(gap);
    end
    idle(CPB);

    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(posedge i_Clock);
      guard++;
    end
    chk("drain_pending", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
